// File: rtl/i2s_dac_tx.sv
// I2S DAC transmitter: divides refclk into BCLK/LRCK and serialises stereo pairs MSB-first.
// Define I2S_LEFT_JUSTIFIED_EN for left-justified framing instead of standard I2S.
module i2s_dac_tx #(
  parameter int SAMPLE_WIDTH  = 16,
  parameter int MCLK_PER_BCLK = 4
) (
  input  logic                    refclk,
  input  logic                    rst,
  input  logic                    locked,
  input  logic [SAMPLE_WIDTH-1:0] in_left,
  input  logic [SAMPLE_WIDTH-1:0] in_right,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic                    bclk,
  output logic                    lrck,
  output logic                    dacdat,
  output logic                    underrun
);

  localparam int DW = (MCLK_PER_BCLK > 2) ? $clog2(MCLK_PER_BCLK) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(MCLK_PER_BCLK - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(MCLK_PER_BCLK / 2);
  localparam logic [5:0]    SW6      = 6'(SAMPLE_WIDTH);

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  state_t                  r_state;
  logic [DW-1:0]           r_div;
  logic [5:0]              r_bit;
  logic                    r_full;
  logic [SAMPLE_WIDTH-1:0] r_hold_l, r_hold_r;
  logic [SAMPLE_WIDTH-1:0] r_word_l, r_word_r;
  logic                    r_bclk, r_lrck, r_dat, r_urun;

  logic                    w_fall, w_load, w_accept, w_bclk_next, w_in_field, w_dat;
  logic [DW-1:0]           w_div_next;
  logic [5:0]              w_bit_next, w_pos6, w_shamt;
  logic [SAMPLE_WIDTH-1:0] w_load_l, w_load_r, w_word, w_shifted;

  assign w_fall      = (r_div == DIV_LAST);
  assign w_div_next  = w_fall ? '0 : r_div + 1'b1;
  assign w_bclk_next = (w_div_next >= DIV_HALF);
  assign w_bit_next  = r_bit + 6'd1;
  assign w_load      = w_fall && (w_bit_next == 6'd0);
  assign w_accept    = in_valid && in_ready;
  assign w_load_l    = r_full ? r_hold_l : '0;
  assign w_load_r    = r_full ? r_hold_r : '0;
  assign w_pos6      = {1'b0, w_bit_next[4:0]};

  // On the load edge the left word is not yet in r_word_l, so take it straight from the load mux.
  assign w_word = w_bit_next[5] ? r_word_r : (w_load ? w_load_l : r_word_l);

`ifdef I2S_LEFT_JUSTIFIED_EN
  assign w_in_field = (w_pos6 < SW6);
  assign w_shamt    = SW6 - 6'd1 - w_pos6;
`else
  assign w_in_field = (w_pos6 != 6'd0) && (w_pos6 <= SW6);
  assign w_shamt    = SW6 - w_pos6;
`endif

  assign w_shifted = w_word >> w_shamt;
  assign w_dat     = w_in_field & w_shifted[0];

  always_ff @(posedge refclk) begin
    if (rst || !locked) begin
      r_state  <= ST_IDLE;
      r_div    <= '0;
      r_bit    <= '0;
      r_full   <= 1'b0;
      r_hold_l <= '0;
      r_hold_r <= '0;
      r_word_l <= '0;
      r_word_r <= '0;
      r_bclk   <= 1'b0;
      r_lrck   <= 1'b0;
      r_dat    <= 1'b0;
      r_urun   <= 1'b0;
    end else if (r_state == ST_IDLE) begin
      // Start one BCLK before the first frame so slot 0 begins on a clean fall event.
      r_state <= ST_RUN;
      r_div   <= '0;
      r_bit   <= 6'd63;
      r_bclk  <= 1'b0;
    end else begin
      r_div  <= w_div_next;
      r_bclk <= w_bclk_next;
      r_urun <= 1'b0;
      if (w_fall) begin
        r_bit  <= w_bit_next;
        r_lrck <= w_bit_next[5];
        r_dat  <= w_dat;
      end
      if (w_load) begin
        r_word_l <= w_load_l;
        r_word_r <= w_load_r;
        r_full   <= 1'b0;
        r_urun   <= !r_full;
      end
      // A pair arriving on an empty-load edge is kept for the following frame.
      if (w_accept) begin
        r_hold_l <= in_left;
        r_hold_r <= in_right;
        r_full   <= 1'b1;
      end
    end
  end

  assign in_ready = (r_state == ST_RUN) && !r_full;
  assign bclk     = r_bclk;
  assign lrck     = r_lrck;
  assign dacdat   = r_dat;
  assign underrun = r_urun;

endmodule

// File: tb/tb_i2s_dac_tx.sv
// Randomised bench for i2s_dac_tx against a frame/slot-level timing model.
module tb_i2s_dac_tx;
  localparam int SW    = 16;
  localparam int M     = 4;
  localparam int FRAME = 64 * M;

  logic          clk = 1'b0;
  logic          rst, locked, in_valid, in_ready, bclk, lrck, dacdat, underrun;
  logic [SW-1:0] in_left, in_right;

  always #5 clk = ~clk;

  i2s_dac_tx #(.SAMPLE_WIDTH(SW), .MCLK_PER_BCLK(M)) dut (
    .refclk(clk), .rst(rst), .locked(locked),
    .in_left(in_left), .in_right(in_right), .in_valid(in_valid),
    .in_ready(in_ready), .bclk(bclk), .lrck(lrck), .dacdat(dacdat), .underrun(underrun)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Model: time since RUN entry plus which words are playing / waiting.
  bit            m_run, m_held, m_urun;
  int            m_k;
  logic [SW-1:0] m_hl, m_hr, m_pl, m_pr;
  bit            want_rst, want_locked;
  int            dut_urun_cnt, dut_hs_cnt, mdl_hs_cnt;

  function automatic logic exp_bclk();
    if (!m_run) return 1'b0;
    return (m_k % M) >= (M / 2);
  endfunction

  function automatic logic exp_lrck();
    int j;
    if (!m_run) return 1'b0;
    j = m_k / M;
    if (j == 0) return 1'b0;
    return (((j - 1) % 64) >= 32);
  endfunction

  function automatic logic exp_dat();
    int j, b, p, idx;
    logic [SW-1:0] w;
    if (!m_run) return 1'b0;
    j = m_k / M;
    if (j == 0) return 1'b0;
    b = (j - 1) % 64;
    p = b % 32;
    w = (b < 32) ? m_pl : m_pr;
`ifdef I2S_LEFT_JUSTIFIED_EN
    if (p >= SW) return 1'b0;
    idx = SW - 1 - p;
`else
    if (p < 1 || p > SW) return 1'b0;
    idx = SW - p;
`endif
    return w[idx];
  endfunction

  task automatic model_edge(input logic v, input logic [SW-1:0] l, input logic [SW-1:0] r,
                            output logic hs);
    hs = 1'b0;
    if (rst || !locked) begin
      m_run = 0; m_held = 0; m_urun = 0; m_k = 0; m_pl = '0; m_pr = '0;
    end else if (!m_run) begin
      m_run = 1; m_k = 0; m_urun = 0;
    end else begin
      hs = v && !m_held;
      m_k++;
      m_urun = 0;
      if (m_k >= M && ((m_k - M) % FRAME) == 0) begin
        if (m_held) begin
          m_pl = m_hl; m_pr = m_hr; m_held = 0;
        end else begin
          m_pl = '0; m_pr = '0; m_urun = 1;
          $display("UNDERRUN k=%0d t=%0t", m_k, $time);
        end
      end
      if (hs) begin
        m_hl = l; m_hr = r; m_held = 1;
        mdl_hs_cnt++;
        $display("ACCEPT L=%h R=%h k=%0d", l, r, m_k - 1);
      end
    end
  endtask

  task automatic cyc(input logic v, input logic [SW-1:0] l, input logic [SW-1:0] r,
                     output logic acc);
    @(negedge clk);
    check("bclk", bclk, exp_bclk());
    check("lrck", lrck, exp_lrck());
    check("dacdat", dacdat, exp_dat());
    check("underrun", underrun, m_urun);
    check("in_ready", in_ready, m_run && !m_held);
    if (underrun) dut_urun_cnt++;
    rst = want_rst; locked = want_locked;
    in_valid = v; in_left = l; in_right = r;
    if (v && in_ready && !rst && locked) dut_hs_cnt++;
    @(posedge clk);
    model_edge(v, l, r, acc);
  endtask

  initial begin
    logic          acc;
    logic [SW-1:0] val;
    rst = 1'b1; locked = 1'b0; in_valid = 1'b0; in_left = '0; in_right = '0;
    want_rst = 1; want_locked = 1;
    m_run = 0; m_held = 0; m_urun = 0; m_k = 0;
    m_hl = '0; m_hr = '0; m_pl = '0; m_pr = '0;
    dut_urun_cnt = 0; dut_hs_cnt = 0; mdl_hs_cnt = 0;

    repeat (6) cyc(1'b0, '0, '0, acc);

    want_rst = 0;
    acc = 0;
    for (int i = 0; i < 20 && !acc; i++) cyc(1'b1, 16'hA5F0, 16'h1234, acc);
    check("first_accept", acc, 1'b1);

    dut_urun_cnt = 0;
    repeat (FRAME - 8) cyc(1'b0, '0, '0, acc);
    check("no_underrun_first_frame", dut_urun_cnt, 0);

    dut_urun_cnt = 0;
    repeat (3 * FRAME) cyc(1'b0, '0, '0, acc);
    check("three_underruns", dut_urun_cnt, 3);

    dut_hs_cnt = 0; mdl_hs_cnt = 0;
    val = 16'h0001;
    repeat (4 * FRAME) begin
      cyc(1'b1, val, ~val, acc);
      if (acc) val++;
    end
    check("stream_accepts", dut_hs_cnt, mdl_hs_cnt);

    repeat (4 * FRAME) cyc($urandom_range(0, 3) == 0, SW'($urandom), SW'($urandom), acc);

    for (int i = 0; i < FRAME && (m_k % FRAME) != 41 * M; i++)
      cyc($urandom_range(0, 1) == 1, SW'($urandom), SW'($urandom), acc);
    check("reached_bit40", m_k % FRAME, 41 * M);
    want_locked = 0;
    repeat (10) cyc(1'b1, SW'($urandom), SW'($urandom), acc);
    want_locked = 1;
    dut_urun_cnt = 0;
    repeat (M + 4) cyc(1'b0, '0, '0, acc);
    check("relock_underrun", dut_urun_cnt, 1);
    repeat (2 * FRAME) cyc($urandom_range(0, 1) == 1, SW'($urandom), SW'($urandom), acc);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
